// File: rtl/nc_pkg.sv
// Shared constants and FSM state encoding for the noise-cancelling frame path.
package nc_pkg;

  localparam int NC_DATA_W    = 32;
  localparam int NC_FRAME_LEN = 128;
  localparam int NC_IDX_W     = 7;

  typedef enum logic [3:0] {
    HSEQ_IDLE = 4'd0,
    HSEQ_RD   = 4'd1,
    HSEQ_LAT  = 4'd2,
    HSEQ_FIRE = 4'd3,
    HSEQ_WAIT = 4'd4,
    HSEQ_WR   = 4'd5,
    HSEQ_NEXT = 4'd6,
    HSEQ_DONE = 4'd7,
    HSEQ_ERR  = 4'd8
  } hseq_state_e;

endpackage

// File: rtl/hann_frame_sequencer.sv
// Frame sequencer for the serial Hanning window unit: per sample it reads the source
// buffer, hands the sample to the window unit, and writes the result to the destination.
module hann_frame_sequencer
  import nc_pkg::*;
#(
  parameter int DATA_W    = NC_DATA_W,
  parameter int FRAME_LEN = NC_FRAME_LEN,
  parameter int IDX_W     = NC_IDX_W,
  parameter int TMO_CYC   = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_go,
  input  logic              abort,
  output logic              src_rd_en,
  output logic [IDX_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              win_start,
  output logic [IDX_W-1:0]  win_index,
  output logic [DATA_W-1:0] win_data,
  input  logic              win_ready,
  input  logic [DATA_W-1:0] win_result,
  output logic              dst_wr_en,
  output logic [IDX_W-1:0]  dst_addr,
  output logic [DATA_W-1:0] dst_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  // The counter holds the number of WAIT cycles already spent, so the
  // TMO_CYC-th unanswered WAIT cycle is the one that gives up.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = '1;

  hseq_state_e      state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tmo_next   = tmo_reg;
    case (state_reg)
      HSEQ_IDLE: begin
        if (frame_go) begin
          state_next = HSEQ_RD;
          idx_next   = '0;
        end
      end
      HSEQ_RD:   state_next = HSEQ_LAT;
      HSEQ_LAT:  state_next = HSEQ_FIRE;
      HSEQ_FIRE: begin
        state_next = HSEQ_WAIT;
        tmo_next   = '0;
      end
      HSEQ_WAIT: begin
        if (win_ready) begin
          state_next = HSEQ_WR;
        end else if (tmo_reg == TMO_LAST) begin
          state_next = HSEQ_ERR;
        end else if (tmo_reg != TMO_SAT) begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      HSEQ_WR:   state_next = HSEQ_NEXT;
      HSEQ_NEXT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = HSEQ_DONE;
        end else begin
          state_next = HSEQ_RD;
          idx_next   = idx_reg + IDX_W'(1);
        end
      end
      HSEQ_DONE: state_next = HSEQ_IDLE;
      HSEQ_ERR:  state_next = HSEQ_IDLE;
      default:   state_next = HSEQ_IDLE;
    endcase
    // abort freezes the frame where it is and drops straight back to IDLE
    if (abort) begin
      state_next = HSEQ_IDLE;
      idx_next   = idx_reg;
      tmo_next   = tmo_reg;
    end
  end

  // Outputs are registered from the next state, so each strobe is high exactly
  // for the cycle the FSM spends in the corresponding state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= HSEQ_IDLE;
      idx_reg     <= '0;
      tmo_reg     <= '0;
      src_rd_en   <= 1'b0;
      src_addr    <= '0;
      win_start   <= 1'b0;
      win_data    <= '0;
      dst_wr_en   <= 1'b0;
      dst_addr    <= '0;
      dst_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tmo_reg   <= tmo_next;
      src_rd_en <= (state_next == HSEQ_RD);
      win_start <= (state_next == HSEQ_FIRE);
      dst_wr_en <= (state_next == HSEQ_WR);
      done      <= (state_next == HSEQ_DONE);
      err       <= (state_next == HSEQ_ERR);
      busy      <= !(state_next inside {HSEQ_IDLE, HSEQ_DONE, HSEQ_ERR});
      if (state_next == HSEQ_RD) begin
        src_addr <= idx_next;
      end
      if (state_reg == HSEQ_LAT && state_next == HSEQ_FIRE) begin
        win_data <= src_rd_data;
      end
      // Only a ready seen in WAIT can lead to WR, so strays never reach the buffer.
      if (state_next == HSEQ_WR) begin
        dst_addr    <= idx_reg;
        dst_wr_data <= win_result;
      end
    end
  end

  assign win_index = idx_reg;

endmodule
